// File: rtl/stream_serializer.sv
// Stream serializer: accepts one wide word and emits it as up to NUM_BEATS
// narrow beats, LSB beat first, with back-to-back reload on the last beat.
module stream_serializer #(
  parameter int unsigned BEAT_W    = 8,
  parameter int unsigned NUM_BEATS = 4,
  localparam int unsigned CNT_W    = $clog2(NUM_BEATS) + 1,
  localparam int unsigned DATA_W   = NUM_BEATS * BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CNT_W-1:0]  in_beats_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BEAT_W-1:0] out_data_o,
  output logic              out_last_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   eff_beats_c;
  logic               last_c;

  // Zero or oversized requests fall back to a full word.
  always_comb begin
    eff_beats_c = in_beats_i;
    if ((in_beats_i == '0) || (in_beats_i > CNT_W'(NUM_BEATS))) begin
      eff_beats_c = CNT_W'(NUM_BEATS);
    end
  end

  // Final beat of the held word.
  always_comb begin
    last_c = (idx_q == (cnt_q - CNT_W'(1)));
  end

  // State, counters and shift register; reset discards any held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and handshake outputs; data is shifted so beat 0 sits in the LSBs.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
      end
      SEND: begin
        out_valid_o = 1'b1;
        out_data_o  = data_q[BEAT_W-1:0];
        out_last_o  = last_c;
        in_ready_o  = last_c && out_ready_i;
        if (out_ready_i) begin
          if (last_c) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + CNT_W'(1);
            data_d = data_q >> BEAT_W;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new word overrides the return to IDLE, giving bubble-free reload.
    if (in_valid_i && in_ready_o) begin
      data_d  = in_data_i;
      cnt_d   = eff_beats_c;
      idx_d   = '0;
      state_d = SEND;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: a beat-queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_stream_serializer;

  localparam int unsigned BEAT_W    = 8;
  localparam int unsigned NUM_BEATS = 4;
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS) + 1;
  localparam int unsigned DATA_W    = NUM_BEATS * BEAT_W;

  logic              clk;
  logic              rst;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CNT_W-1:0]  in_beats_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [BEAT_W-1:0] out_data_o;
  logic              out_last_o;

  stream_serializer #(.BEAT_W(BEAT_W), .NUM_BEATS(NUM_BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_beats_i (in_beats_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BEAT_W-1:0] d;
    logic              l;
  } beat_t;

  typedef struct {
    logic [BEAT_W-1:0] d;
    logic              l;
    int                cyc;
  } obs_t;

  beat_t exp_q[$];
  obs_t  obs_q[$];
  int    cyc;
  int    in_cyc;
  int    n_checks;
  int    n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Model: pending beats of the accepted word, in emission order.
  always @(negedge clk) begin
    logic  exp_ready;
    int    eff;
    beat_t b;
    obs_t  o;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_ready", 32'(in_ready_o), 32'd1);
      chk("rst_data", 32'(out_data_o), 32'd0);
      chk("rst_last", 32'(out_last_o), 32'd0);
    end else begin
      exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready_i);
      chk("valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready_o), 32'(exp_ready));
      if (exp_q.size() != 0) begin
        chk("data", 32'(out_data_o), 32'(exp_q[0].d));
        chk("last", 32'(out_last_o), 32'(exp_q[0].l));
      end else begin
        chk("idle_data", 32'(out_data_o), 32'd0);
        chk("idle_last", 32'(out_last_o), 32'd0);
      end
      if (out_valid_o && out_ready_i) begin
        o.d = out_data_o; o.l = out_last_o; o.cyc = cyc;
        obs_q.push_back(o);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid_i && exp_ready) begin
        in_cyc = cyc;
        eff = ((in_beats_i == 0) || (in_beats_i > NUM_BEATS)) ? NUM_BEATS : int'(in_beats_i);
        for (int k = 0; k < eff; k++) begin
          b.d = in_data_i[k*BEAT_W +: BEAT_W];
          b.l = (k == eff - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  // Offer one word and return just after the edge that accepts it.
  task automatic send_word(input logic [DATA_W-1:0] w, input logic [CNT_W-1:0] n);
    bit done;
    done = 0;
    in_valid_i = 1'b1;
    in_data_i  = w;
    in_beats_i = n;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid_i = 1'b0;
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  // Wait until all modeled beats have drained and the DUT is idle.
  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid_o) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string name, input int i, input logic [7:0] d, input logic l);
    if (i < obs_q.size()) begin
      chk({name, "_d"}, 32'(obs_q[i].d), 32'(d));
      chk({name, "_l"}, 32'(obs_q[i].l), 32'(l));
    end else begin
      chk({name, "_missing"}, 32'(obs_q.size()), 32'(i + 1));
    end
  endtask

  int base;

  initial begin
    cyc = 0; in_cyc = 0; n_checks = 0; n_pass = 0;
    rst = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0; in_beats_i = '0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready_o), 32'd1);
    chk("post_rst_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk); #1;

    // Single full word, beats on cycles 1..4 after acceptance.
    out_ready_i = 1'b1;
    obs_q.delete();
    send_word(32'h44332211, 3'd0);
    wait_idle();
    chk("single_n", 32'(obs_q.size()), 32'd4);
    chk_obs("single0", 0, 8'h11, 1'b0);
    chk_obs("single1", 1, 8'h22, 1'b0);
    chk_obs("single2", 2, 8'h33, 1'b0);
    chk_obs("single3", 3, 8'h44, 1'b1);
    for (int i = 0; i < obs_q.size(); i++) chk("single_cyc", 32'(obs_q[i].cyc), 32'(in_cyc + 1 + i));

    // Short word of two beats.
    obs_q.delete();
    send_word(32'hDDCCBBAA, 3'd2);
    wait_idle();
    chk("short_n", 32'(obs_q.size()), 32'd2);
    chk_obs("short0", 0, 8'hAA, 1'b0);
    chk_obs("short1", 1, 8'hBB, 1'b1);
    @(negedge clk);
    chk("short_ready_after", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;

    // Stall three cycles on the second beat.
    obs_q.delete();
    out_ready_i = 1'b0;
    send_word(32'h44332211, 3'd4);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", 32'(out_data_o), 32'h22);
      chk("stall_valid", 32'(out_valid_o), 32'd1);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    wait_idle();
    chk("stall_n", 32'(obs_q.size()), 32'd4);
    chk_obs("stall0", 0, 8'h11, 1'b0);
    chk_obs("stall1", 1, 8'h22, 1'b0);
    chk_obs("stall2", 2, 8'h33, 1'b0);
    chk_obs("stall3", 3, 8'h44, 1'b1);

    // Back-to-back words with in_valid held.
    obs_q.delete();
    send_word(32'h04030201, 3'd0);
    send_word(32'h08070605, 3'd0);
    wait_idle();
    chk("b2b_n", 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      chk("b2b_d", 32'(obs_q[i].d), 32'(i + 1));
      chk("b2b_l", 32'(obs_q[i].l), 32'((i == 3) || (i == 7)));
      if (i > 0) chk("b2b_gap", 32'(obs_q[i].cyc - obs_q[i-1].cyc), 32'd1);
    end

    // Oversized count is clamped to a full word.
    obs_q.delete();
    send_word(32'h87654321, 3'd7);
    wait_idle();
    chk("over_n", 32'(obs_q.size()), 32'd4);
    chk_obs("over0", 0, 8'h21, 1'b0);
    chk_obs("over3", 3, 8'h87, 1'b1);

    // Reset mid-word after beat 0x22.
    obs_q.delete();
    send_word(32'h44332211, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
    chk("mid_rst_data", 32'(out_data_o), 32'd0);
    chk("mid_rst_seen", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) chk("mid_rst_lastbeat", 32'(obs_q[1].d), 32'h22);
    base = obs_q.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_residual", 32'(obs_q.size()), 32'(base));
    chk("mid_rst_idle", 32'(out_valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
